// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: steps the 4-bit ALU through all eight operations on latched
// switch operands, holds each one for DWELL_CYCLES, feeds the result to the
// segment driver and sums the eight results into an 8-bit checksum.
// Optional feature: define ALU_SEQ_LOOP_EN for continuous loop mode.
// In loop mode, done pulses at every 7->0 wrap and only abort/reset stop the run.
module alu_seq_ctrl #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic [3:0] ALU_Out,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] ALU_Sel,
  output logic [3:0] Disp_Val,
  output logic       busy,
  output logic       done,
  output logic [7:0] chk
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic             r_startPrev;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [2:0]       r_sel;
  logic [3:0]       r_disp;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_chk;

  logic             w_startEdge;
  logic             w_dwellEnd;
  logic [7:0]       w_result;

  assign w_startEdge = start & ~r_startPrev;
  assign w_dwellEnd  = (r_cnt == LP_DWELL_LAST);
  assign w_result    = {4'b0000, ALU_Out};

  assign A        = r_a;
  assign B        = r_b;
  assign ALU_Sel  = r_sel;
  assign Disp_Val = r_disp;
  assign busy     = r_busy;
  assign done     = r_done;
  assign chk      = r_chk;

  // Sequencer FSM: start-edge detect, dwell timing, op stepping and checksum accumulation
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_startPrev <= 1'b1;
      r_cnt       <= '0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_sel       <= 3'd0;
      r_disp      <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_chk       <= 8'd0;
    end else begin
      r_startPrev <= start;
      r_done      <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_sel   <= 3'd0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_startEdge) begin
              r_a     <= A_in;
              r_b     <= B_in;
              r_sel   <= 3'd0;
              r_cnt   <= '0;
              r_chk   <= 8'd0;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_disp <= ALU_Out;
            if (w_dwellEnd) begin
              r_cnt <= '0;
`ifdef ALU_SEQ_LOOP_EN
              r_chk <= (r_done ? 8'd0 : r_chk) + w_result;
              r_sel <= r_sel + 3'd1;
              if (r_sel == 3'd7) begin
                r_done <= 1'b1;
              end
`else
              r_chk <= r_chk + w_result;
              if (r_sel == 3'd7) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_sel <= r_sel + 3'd1;
              end
`endif
            end else begin
              r_cnt <= r_cnt + LP_CNT_ONE;
`ifdef ALU_SEQ_LOOP_EN
              if (r_done) begin
                r_chk <= 8'd0;
              end
`endif
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 4-bit ALU display path. On a start request it latches the switch operands, steps `ALU_Sel` through all eight operations with a programmable dwell per operation, and feeds the ALU result to the 7-segment display driver. It also accumulates an 8-bit checksum of the eight results for self-check. It sits between the board switches/buttons and the existing ALU and segment driver inside the top-level wrapper.

## Interface
- `DWELL_CYCLES`, default 50_000_000: cycles each operation is held; legal range ≥ 1.
- `CNT_W`, default 26: dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYCLES.

- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  debounced start button, level; the rising edge is detected internally.
- `abort`  in  1  synchronous stop, level.
- `A_in`, `B_in`  in  4 each  operand switches.
- `ALU_Out`  in  4  combinational result from the ALU.
- `A`, `B`  out  4 each  latched operands driven to the ALU.
- `ALU_Sel`  out  3  current operation select.
- `Disp_Val`  out  4  value sent to the segment driver.
- `busy`  out  1  high while a sequence runs.
- `done`  out  1  one-cycle pulse at sequence completion.
- `chk`  out  8  checksum of the results; valid when `done` pulses.

## Operation
- **Reset values:**
  - `A`, `B`, `ALU_Sel`, `Disp_Val`, `chk`, `busy`, `done` and the dwell counter are all 0.
  - State is IDLE.
  - The start-edge register resets to 1, so a button held through reset does not launch a sequence.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - A start edge (`start`=1, previous `start`=0) with `abort`=0 latches `A_in`/`B_in` into `A`/`B`.
  - It also sets `ALU_Sel`=0, counter=0, `chk`=0, `busy`=1, and moves to RUN.
- **RUN:**
  - The counter increments every cycle.
  - `Disp_Val` registers `ALU_Out` every cycle.
  - At counter = DWELL_CYCLES−1:
    - `chk` += zero-extended `ALU_Out`, mod 256.
    - The counter clears.
    - If `ALU_Sel`=7, go to DONE; otherwise `ALU_Sel`+1.
- **DONE:** lasts exactly one cycle with `done`=1. Then IDLE with `busy`=0.
- **Held in IDLE:** `A`, `B`, `ALU_Sel`(=7), `Disp_Val` and `chk` all hold.
- **Start edges:** ignored while `busy`=1.
- **`abort`=1 in any state:**
  - Next state is IDLE, with `busy`=0, `ALU_Sel`=0 and counter=0.
  - No `done` pulse.
  - `Disp_Val`, `A` and `B` hold; `chk` is not valid.
- **Priority:**
  - `reset` beats `abort`, which beats a start edge.
  - If a start edge and `abort` arrive in the same cycle, the controller stays in IDLE and the start edge is consumed.
- **Reset mid-sequence:** immediate return to reset values on the next edge; no `done` pulse.

## Timing
- If the start edge is sampled at clock edge k:
  - `busy`, `A`, `B` and `ALU_Sel`=0 are visible after edge k.
  - Operation n (0..7) occupies cycles k+n·DWELL_CYCLES+1 … k+(n+1)·DWELL_CYCLES.
- `done` is high for the single cycle after edge k+8·DWELL_CYCLES. `busy` falls on the following edge.
- `Disp_Val` lags `ALU_Out` by exactly one cycle.
- With DWELL_CYCLES=1, `ALU_Sel` advances every cycle and RUN lasts 8 cycles.
- Sequence-to-sequence: a new start edge is accepted in the first IDLE cycle after DONE.

## Configuration
- **Macro `ALU_SEQ_LOOP_EN`.**
- **Defined:** loop mode.
  - After operation 7, `ALU_Sel` wraps to 0 and RUN continues with the same latched operands.
  - `done` pulses for one cycle at each wrap, coincident with `ALU_Sel` returning to 0.
  - `chk` is presented, then cleared, at each wrap.
  - Only `abort` or `reset` ends the sequence.
- **Undefined:** single-pass behaviour as specified above; DONE is entered after operation 7.

## Test plan
1. **Single pass.** DWELL_CYCLES=4, `A_in`=3, `B_in`=5, start pulse.
   - `busy`=1 for 33 cycles.
   - `ALU_Sel` steps 0→7, holding each value 4 cycles.
   - `done` pulses once.
   - `chk` = sum mod 256 of the model ALU results for ops 0–7 on (3,5).
2. **Reset with start held.** Hold `start`=1 through `reset` and for 10 cycles after.
   - `busy` stays 0.
   - Release, then press again: the sequence runs.
3. **Abort mid-run.** `abort` at op 4, second dwell cycle.
   - Next cycle: `busy`=0, `ALU_Sel`=0, no `done`.
   - `Disp_Val` holds the op-4 result.
4. **Ignored start, operands locked.** Start re-pressed and `A_in` changed to 9 during RUN.
   - No restart, and `A` stays 3.
   - A second start after DONE latches 9.
5. **Minimum dwell and same-cycle conflict.** DWELL_CYCLES=1: `ALU_Sel` changes every cycle, `done` 9 cycles after start.
   - Start and `abort` in the same cycle: remains IDLE.
6. **Loop mode.** `ALU_SEQ_LOOP_EN` defined, DWELL_CYCLES=2.
   - `done` pulses every 16 cycles.
   - `ALU_Sel` goes 7→0 with no idle gap.
   - `abort` ends the sequence.
